// File: rtl/par_ser_tx_32.sv
// par_ser_tx_32 - parallel-to-serial transmitter with a small word buffer.
//
// Accepts WIDTH-bit words on a valid/ready handshake into a DEPTH-entry
// circular FIFO. Each word is shifted out LSB-first on Ser_out with En
// qualifying every bit. Queued words follow each other with no idle cycle,
// so a downstream serial-to-parallel converter stays word-aligned.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   Data_in    word to transmit, sampled when load && ready
//   load       word valid
//   ready      buffer can accept a word this cycle (registered state only)
//   Ser_out    serial data bit, LSB first (registered)
//   En         Ser_out carries a valid bit this cycle (registered)
//   word_done  pulse in the cycle carrying bit WIDTH-1 of a word (registered)
//   busy       shifter active or buffer non-empty
module par_ser_tx_32 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Data_in,
   input  logic             load,
   output logic             ready,
   output logic             Ser_out,
   output logic             En,
   output logic             word_done,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);

   localparam logic [0:0]    S_IDLE  = 1'b0;
   localparam logic [0:0]    S_SHIFT = 1'b1;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

   // Word buffer
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // Shifter
   logic [0:0]       state;
   logic [0:0]       state_nx;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_nx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;

   logic             push;
   logic             pop;
   logic             has_word;
   logic             last_bit;

   assign has_word = (count != '0);
   assign last_bit = (state == S_SHIFT) && (cnt == LAST_BIT);

   assign ready = !rst && (count < FULL_CNT);
   assign push  = load && ready;

   // The next word is taken either from idle or on the edge that ends the
   // current word's last bit, which is what keeps En gap-free.
   assign pop   = has_word && ((state == S_IDLE) || last_bit);

   assign busy  = (state == S_SHIFT) || has_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= Data_in;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      shift_nx = shift_reg;
      cnt_nx   = cnt;
      if (pop) begin
         state_nx = S_SHIFT;
         shift_nx = mem[rd_ptr];
         cnt_nx   = '0;
      end else if (state == S_SHIFT) begin
         shift_nx = shift_reg >> 1;
         if (last_bit) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx   = cnt + 1'b1;
         end
      end
   end

   // Outputs are registered from the next-state values so that they line
   // up exactly with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         shift_reg <= '0;
         cnt       <= '0;
         Ser_out   <= 1'b0;
         En        <= 1'b0;
         word_done <= 1'b0;
      end else begin
         state     <= state_nx;
         shift_reg <= shift_nx;
         cnt       <= cnt_nx;
         En        <= (state_nx == S_SHIFT);
         Ser_out   <= (state_nx == S_SHIFT) && shift_nx[0];
         word_done <= (state_nx == S_SHIFT) && (cnt_nx == LAST_BIT);
      end
   end

endmodule

// File: tb/tb_par_ser_tx_32.sv
// Testbench for par_ser_tx_32.
module tb_par_ser_tx_32;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic [31:0] Data_in;
   logic        load;
   logic        ready;
   logic        Ser_out;
   logic        En;
   logic        word_done;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   par_ser_tx_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .Data_in   (Data_in),
      .load      (load),
      .ready     (ready),
      .Ser_out   (Ser_out),
      .En        (En),
      .word_done (word_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of buffered words plus the word in flight and
   // the number of its bits still to be sent.
   logic [31:0] m_q[$];
   logic [31:0] sent_q[$];
   logic [31:0] m_sh = '0;
   int          m_left = 0;

   always @(posedge clk) begin : model_b
      bit acc;
      if (rst) begin
         m_q.delete();
         m_left = 0;
         m_sh   = '0;
      end else begin
         acc = load && (m_q.size() < DEPTH);
         if (m_q.size() > 0 && m_left <= 1) begin
            m_sh   = m_q.pop_front();
            m_left = WIDTH;
         end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_sh   = m_sh >> 1;
         end
         if (acc) begin
            m_q.push_back(Data_in);
            sent_q.push_back(Data_in);
         end
      end
   end

   function automatic logic m_en();    return m_left > 0;                       endfunction
   function automatic logic m_ser();   return (m_left > 0) ? m_sh[0] : 1'b0;    endfunction
   function automatic logic m_wd();    return m_left == 1;                      endfunction
   function automatic logic m_busy();  return (m_left > 0) || (m_q.size() > 0); endfunction
   function automatic logic m_ready(); return !rst && (m_q.size() < DEPTH);     endfunction

   // Serial receiver: rebuilds words from the En-qualified stream.
   logic [31:0] recv_q[$];
   logic [31:0] rx_sh = '0;
   int          rx_n = 0;
   // En run length and word_done timing statistics.
   bit          stats_clr = 0;
   int          cyc_no = 0;
   int          cur_run = 0;
   int          max_run = 0;
   int          wd_bad = 0;
   int          wd_q[$];

   always @(negedge clk) begin
      cyc_no = cyc_no + 1;
      if (rst) begin
         rx_n = 0;
      end else if (En) begin
         rx_sh = {Ser_out, rx_sh[31:1]};
         rx_n  = rx_n + 1;
         if (rx_n == WIDTH) begin
            recv_q.push_back(rx_sh);
            rx_n = 0;
         end
      end
      if (stats_clr) begin
         cur_run = 0;
         max_run = 0;
         wd_bad  = 0;
         wd_q.delete();
      end else begin
         cur_run = En ? cur_run + 1 : 0;
         if (cur_run > max_run) max_run = cur_run;
         if (word_done) begin
            wd_q.push_back(cyc_no);
            if (!En) wd_bad = wd_bad + 1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w, output bit ok);
      load    = 1'b1;
      Data_in = w;
      ok      = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (ready) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
      if (ok) cyc();
      load = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         if (!busy && !En) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
      repeat (3) cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; Data_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (ready !== 1'b0)     $display("FAIL reset_ready: got %b want 0", ready);     else n_pass++;
      n_chk++; if (En !== 1'b0)        $display("FAIL reset_en: got %b want 0", En);           else n_pass++;
      n_chk++; if (Ser_out !== 1'b0)   $display("FAIL reset_ser: got %b want 0", Ser_out);     else n_pass++;
      n_chk++; if (word_done !== 1'b0) $display("FAIL reset_wd: got %b want 0", word_done);    else n_pass++;
      n_chk++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy);       else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (ready !== 1'b1)     $display("FAIL post_reset_ready: got %b want 1", ready); else n_pass++;
   endtask

   task automatic test_single_word();
      bit   ok;
      logic en_v[40], ser_v[40], wd_v[40], busy_v[40];
      int   en_cnt, first_en, last_en, mid_ones, wd_cnt, wd_idx;
      push_word(32'h8000_0001, ok);
      n_chk++; if (ok !== 1'b1) $display("FAIL single_push_timeout: got %b want 1", ok); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         en_v[i] = En; ser_v[i] = Ser_out; wd_v[i] = word_done; busy_v[i] = busy;
      end
      en_cnt = 0; first_en = -1; last_en = -1; mid_ones = 0; wd_cnt = 0; wd_idx = -1;
      for (int i = 0; i < 40; i++) begin
         if (en_v[i] === 1'b1) begin
            en_cnt++;
            if (first_en < 0) first_en = i;
            last_en = i;
         end
         if (wd_v[i] === 1'b1) begin wd_cnt++; wd_idx = i; end
      end
      for (int i = 2; i <= 31; i++) if (ser_v[i] !== 1'b0) mid_ones++;
      n_chk++; if (first_en != 1)      $display("FAIL single_latency: got %0d want 1", first_en);  else n_pass++;
      n_chk++; if (en_cnt != 32)       $display("FAIL single_en_count: got %0d want 32", en_cnt);  else n_pass++;
      n_chk++; if (last_en != 32)      $display("FAIL single_last_en: got %0d want 32", last_en);  else n_pass++;
      n_chk++; if (ser_v[1] !== 1'b1)  $display("FAIL single_bit0: got %b want 1", ser_v[1]);      else n_pass++;
      n_chk++; if (mid_ones != 0)      $display("FAIL single_mid_bits: got %0d ones want 0", mid_ones); else n_pass++;
      n_chk++; if (ser_v[32] !== 1'b1) $display("FAIL single_bit31: got %b want 1", ser_v[32]);    else n_pass++;
      n_chk++; if (wd_cnt != 1)        $display("FAIL single_wd_count: got %0d want 1", wd_cnt);   else n_pass++;
      n_chk++; if (wd_idx != 32)       $display("FAIL single_wd_pos: got %0d want 32", wd_idx);    else n_pass++;
      n_chk++; if (busy_v[0] !== 1'b1) $display("FAIL single_busy_pending: got %b want 1", busy_v[0]); else n_pass++;
      n_chk++; if (busy_v[33] !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy_v[33]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[3];
      bit ok, ok_all;
      int rb;
      w[0] = 32'hA5A5_A5A5; w[1] = 32'h0000_FFFF; w[2] = 32'h1234_5678;
      rb = recv_q.size();
      stats_clr = 1'b1; @(negedge clk); #1; stats_clr = 1'b0;
      ok_all = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_word(w[i], ok);
         ok_all &= ok;
      end
      wait_idle(ok);
      n_chk++; if (!(ok_all && ok)) $display("FAIL b2b_timeout: got %b want 1", ok_all && ok); else n_pass++;
      n_chk++; if (max_run != 96)   $display("FAIL b2b_en_run: got %0d want 96", max_run);      else n_pass++;
      n_chk++; if (recv_q.size() - rb != 3) $display("FAIL b2b_word_count: got %0d want 3", recv_q.size() - rb);
               else n_pass++;
      for (int i = 0; i < 3; i++) begin
         if (rb + i < recv_q.size()) begin
            n_chk++;
            if (recv_q[rb+i] !== w[i]) $display("FAIL b2b_word%0d: got %h want %h", i, recv_q[rb+i], w[i]);
            else n_pass++;
         end
      end
      n_chk++; if (wd_q.size() != 3) $display("FAIL b2b_wd_count: got %0d want 3", wd_q.size()); else n_pass++;
      if (wd_q.size() == 3) begin
         n_chk++; if (wd_q[1] - wd_q[0] != 32) $display("FAIL b2b_wd_gap1: got %0d want 32", wd_q[1] - wd_q[0]); else n_pass++;
         n_chk++; if (wd_q[2] - wd_q[1] != 32) $display("FAIL b2b_wd_gap2: got %0d want 32", wd_q[2] - wd_q[1]); else n_pass++;
      end
      n_chk++; if (wd_bad != 0) $display("FAIL b2b_wd_without_en: got %0d want 0", wd_bad); else n_pass++;
   endtask

   task automatic test_full_buffer();
      logic [31:0] w[5];
      logic        rdy_arr[200];
      int rb, acc, e0, low_n;
      bit ok;
      for (int i = 0; i < 5; i++) w[i] = {24'($urandom), 8'(i)};
      for (int i = 0; i < 200; i++) rdy_arr[i] = 1'bx;
      rb = recv_q.size(); acc = 0; e0 = -1;
      load = 1'b1; Data_in = w[0];
      for (int c = 0; c < 200 && acc < 5; c++) begin
         @(negedge clk);
         rdy_arr[c] = ready;
         @(posedge clk); #1;
         if (rdy_arr[c] === 1'b1) begin
            if (acc == 0) e0 = c;
            acc++;
            if (acc < 5) Data_in = w[acc]; else load = 1'b0;
         end
      end
      load = 1'b0;
      n_chk++; if (acc != 5) $display("FAIL full_accept_count: got %0d want 5", acc); else n_pass++;
      if (e0 >= 0 && e0 + 34 < 200) begin
         low_n = 0;
         for (int c = e0 + 3; c <= e0 + 33; c++) if (rdy_arr[c] === 1'b0) low_n++;
         n_chk++; if (rdy_arr[e0+2] !== 1'b1) $display("FAIL full_third_accept: got %b want 1", rdy_arr[e0+2]); else n_pass++;
         n_chk++; if (rdy_arr[e0+3] !== 1'b0) $display("FAIL full_ready_drop: got %b want 0", rdy_arr[e0+3]); else n_pass++;
         n_chk++; if (low_n != 31)            $display("FAIL full_ready_low_len: got %0d want 31", low_n);    else n_pass++;
         n_chk++; if (rdy_arr[e0+34] !== 1'b1) $display("FAIL full_ready_return: got %b want 1", rdy_arr[e0+34]); else n_pass++;
      end
      wait_idle(ok);
      n_chk++; if (ok !== 1'b1) $display("FAIL full_drain_timeout: got %b want 1", ok); else n_pass++;
      n_chk++; if (recv_q.size() - rb != 5) $display("FAIL full_word_count: got %0d want 5", recv_q.size() - rb); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         if (rb + i < recv_q.size()) begin
            n_chk++;
            if (recv_q[rb+i] !== w[i]) $display("FAIL full_word%0d: got %h want %h", i, recv_q[rb+i], w[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_ignored_load();
      logic [31:0] w[3];
      int rb, rdy_hi, bad;
      bit ok, ok_all;
      for (int i = 0; i < 3; i++) w[i] = $urandom;
      rb = recv_q.size(); ok_all = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_word(w[i], ok);
         ok_all &= ok;
      end
      load = 1'b1; Data_in = 32'hDEAD_BEEF; rdy_hi = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ready !== 1'b0) rdy_hi++;
         @(posedge clk); #1;
      end
      load = 1'b0;
      n_chk++; if (rdy_hi != 0) $display("FAIL ign_ready_high: got %0d cycles want 0", rdy_hi); else n_pass++;
      wait_idle(ok);
      n_chk++; if (!(ok && ok_all)) $display("FAIL ign_timeout: got %b want 1", ok && ok_all); else n_pass++;
      n_chk++; if (recv_q.size() - rb != 3) $display("FAIL ign_word_count: got %0d want 3", recv_q.size() - rb); else n_pass++;
      bad = 0;
      for (int i = rb; i < recv_q.size(); i++) if (recv_q[i] === 32'hDEAD_BEEF) bad++;
      n_chk++; if (bad != 0) $display("FAIL ign_deadbeef_sent: got %0d want 0", bad); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         if (rb + i < recv_q.size()) begin
            n_chk++;
            if (recv_q[rb+i] !== w[i]) $display("FAIL ign_word%0d: got %h want %h", i, recv_q[rb+i], w[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] nw, got;
      int rb, en_seen;
      bit ok, ok2;
      push_word(32'hFFFF_FFFF, ok);
      push_word(32'h0F0F_0F0F, ok2);
      n_chk++; if (!(ok && ok2)) $display("FAIL rmid_push_timeout: got %b want 1", ok && ok2); else n_pass++;
      repeat (10) cyc();
      rst = 1'b1;
      @(negedge clk);
      n_chk++; if (En !== 1'b1 || Ser_out !== 1'b1) $display("FAIL rmid_bit10: got en=%b ser=%b want en=1 ser=1", En, Ser_out);
               else n_pass++;
      n_chk++; if (ready !== 1'b0) $display("FAIL rmid_ready_in_rst: got %b want 0", ready); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (En !== 1'b0)      $display("FAIL rmid_en: got %b want 0", En);        else n_pass++;
      n_chk++; if (busy !== 1'b0)    $display("FAIL rmid_busy: got %b want 0", busy);    else n_pass++;
      n_chk++; if (Ser_out !== 1'b0) $display("FAIL rmid_ser: got %b want 0", Ser_out);  else n_pass++;
      n_chk++; if (ready !== 1'b1)   $display("FAIL rmid_ready: got %b want 1", ready);   else n_pass++;
      rb = recv_q.size(); en_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (En !== 1'b0) en_seen++;
      end
      n_chk++; if (en_seen != 0 || recv_q.size() != rb) $display("FAIL rmid_queued_sent: got %0d en cycles want 0", en_seen);
               else n_pass++;
      nw = $urandom;
      push_word(nw, ok);
      @(negedge clk);
      n_chk++; if (En !== 1'b0) $display("FAIL rmid_new_early: got %b want 0", En); else n_pass++;
      @(negedge clk);
      n_chk++; if (En !== 1'b1) $display("FAIL rmid_new_latency: got %b want 1", En); else n_pass++;
      got = '0;
      got[0] = Ser_out;
      for (int b = 1; b < 32; b++) begin
         @(negedge clk);
         got[b] = Ser_out & En;
      end
      n_chk++; if (got !== nw) $display("FAIL rmid_new_word: got %h want %h", got, nw); else n_pass++;
      wait_idle(ok);
   endtask

   task automatic test_random_loopback();
      int  sb, rb, acc, errs;
      bit  pending, rdy, ok;
      sb = sent_q.size(); rb = recv_q.size();
      pending = 1'b0; acc = 0; load = 1'b0;
      for (int c = 0; c < 3000 && acc < 20; c++) begin
         if (!pending && $urandom_range(0, 2) != 0) begin
            pending = 1'b1;
            Data_in = $urandom;
         end
         load = pending;
         @(negedge clk);
         n_chk++; if (ready !== m_ready())     $display("FAIL rnd_ready c%0d: got %b want %b", c, ready, m_ready());        else n_pass++;
         n_chk++; if (En !== m_en())           $display("FAIL rnd_en c%0d: got %b want %b", c, En, m_en());                 else n_pass++;
         n_chk++; if (Ser_out !== m_ser())     $display("FAIL rnd_ser c%0d: got %b want %b", c, Ser_out, m_ser());          else n_pass++;
         n_chk++; if (word_done !== m_wd())    $display("FAIL rnd_wd c%0d: got %b want %b", c, word_done, m_wd());          else n_pass++;
         n_chk++; if (busy !== m_busy())       $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy());           else n_pass++;
         rdy = ready;
         @(posedge clk); #1;
         if (load && rdy) begin
            pending = 1'b0;
            acc++;
         end
      end
      load = 1'b0;
      wait_idle(ok);
      n_chk++; if (!ok || acc != 20) $display("FAIL rnd_accept: got %0d want 20", acc); else n_pass++;
      n_chk++; if (sent_q.size() - sb != 20) $display("FAIL rnd_model_count: got %0d want 20", sent_q.size() - sb); else n_pass++;
      n_chk++; if (recv_q.size() - rb != 20) $display("FAIL rnd_recv_count: got %0d want 20", recv_q.size() - rb); else n_pass++;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         if (rb + i < recv_q.size() && sb + i < sent_q.size()) begin
            n_chk++;
            if (recv_q[rb+i] !== sent_q[sb+i]) begin
               errs++;
               $display("FAIL rnd_word%0d: got %h want %h", i, recv_q[rb+i], sent_q[sb+i]);
            end else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_full_buffer();
      test_ignored_load();
      test_reset_mid();
      test_random_loopback();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
